// File: rtl/packet_issue_pkg.sv
// Shared definitions for the packet issue stage and the packet fetch stage.
package packet_issue_pkg;

  localparam int PW_DEF    = 38;
  localparam int PCW_DEF   = 5;
  localparam int DEPTH_DEF = 4;
  localparam int END_BIT   = PW_DEF - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_UPDATE  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/packet_issue_fifo.sv
// pkt_fifo: synchronous show-ahead FIFO; the head entry is visible on rdata
// without a pop, and rdata reads zero whenever the FIFO is empty.
module pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Show-ahead head with a clean zero while empty.
  always_comb begin
    rdata = {W{1'b0}};
    if (empty) begin
      rdata = {W{1'b0}};
    end else begin
      rdata = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/packet_issue.sv
// packet_issue: issue stage that walks the fetch stage's program into a FIFO
// and streams it downstream. Optional statistics: define PACKET_ISSUE_STATS_EN.
module packet_issue
  import packet_issue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PW    = PW_DEF,
  parameter int PCW   = PCW_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [PW-1:0]          PACKET_IN,
  input  logic [PCW-1:0]         PC_IN,
  output logic                   PC_UPDATE,
  output logic                   PKT_VALID,
  output logic [PW-1:0]          PKT_DATA,
  input  logic                   PKT_READY,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [$clog2(DEPTH):0] COUNT
`ifdef PACKET_ISSUE_STATS_EN
  ,
  output logic [15:0]            ISSUED_CNT,
  output logic [15:0]            STALL_CNT
`endif
);

  localparam int END_POS = (PW == PW_DEF) ? END_BIT : PW - 1;

  state_t state_r;
  logic   pc_update_r;
  logic   busy_r;
  logic   done_r;
  logic   fifo_full_s;
  logic   fifo_empty_s;
  logic   push_s;
  logic   pop_s;
  logic   last_s;
  logic   start_ok_s;

  // The last PC is captured without a PC update so the fetch PC never wraps.
  assign last_s     = PACKET_IN[END_POS] | (PC_IN == {PCW{1'b1}});
  assign push_s     = (state_r == ST_CAPTURE) & ~fifo_full_s;
  assign pop_s      = PKT_VALID & PKT_READY;
  assign start_ok_s = START & ((state_r == ST_IDLE) | (state_r == ST_DONE));

  pkt_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (PACKET_IN),
    .rdata (PKT_DATA),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (COUNT)
  );

  assign PKT_VALID = ~fifo_empty_s;
  assign PC_UPDATE = pc_update_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;

  // Issue FSM with its status outputs registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      pc_update_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      pc_update_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state_r <= ST_CAPTURE;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!fifo_full_s) begin
            if (last_s) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r     <= ST_UPDATE;
              pc_update_r <= 1'b1;
            end
          end
        end
        ST_UPDATE: state_r <= ST_SETTLE;
        ST_SETTLE: state_r <= ST_CAPTURE;
        ST_DRAIN: begin
          if (fifo_empty_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACKET_ISSUE_STATS_EN
  logic [15:0] issued_r;
  logic [15:0] stall_r;

  // Saturating handshake and full-stall counters, cleared by an accepted START.
  always_ff @(posedge CLK) begin
    if (RST || start_ok_s) begin
      issued_r <= 16'h0000;
      stall_r  <= 16'h0000;
    end else begin
      if (pop_s && (issued_r != 16'hFFFF)) begin
        issued_r <= issued_r + 16'h0001;
      end
      if ((state_r == ST_CAPTURE) && fifo_full_s && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'h0001;
      end
    end
  end

  assign ISSUED_CNT = issued_r;
  assign STALL_CNT  = stall_r;
`else
  // Statistics counters are not built in this configuration.
  logic unused_start_ok_s;
  assign unused_start_ok_s = start_ok_s;
`endif

endmodule

// File: tb/tb_packet_issue.sv
// Directed bench for packet_issue with a fetch-stage model and a program-order
// scoreboard derived from the program contents.
module tb_packet_issue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [37:0] PACKET_IN;
  logic [4:0]  PC_IN;
  logic        PC_UPDATE;
  logic        PKT_VALID;
  logic [37:0] PKT_DATA;
  logic        PKT_READY;
  logic        BUSY;
  logic        DONE;
  logic [2:0]  COUNT;
`ifdef PACKET_ISSUE_STATS_EN
  logic [15:0] ISSUED_CNT;
  logic [15:0] STALL_CNT;
`endif

  packet_issue dut (
    .CLK(CLK), .RST(RST), .START(START), .PACKET_IN(PACKET_IN), .PC_IN(PC_IN),
    .PC_UPDATE(PC_UPDATE), .PKT_VALID(PKT_VALID), .PKT_DATA(PKT_DATA),
    .PKT_READY(PKT_READY), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT)
`ifdef PACKET_ISSUE_STATS_EN
    , .ISSUED_CNT(ISSUED_CNT), .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Fetch stage model: program memory indexed by a PC advanced on PC_UPDATE.
  logic [37:0] prog [32];
  logic [4:0]  pc;
  always @(posedge CLK) begin
    if (RST) pc <= 5'd0;
    else if (PC_UPDATE) pc <= pc + 5'd1;
  end
  assign PC_IN     = pc;
  assign PACKET_IN = prog[pc];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [37:0] exp_q [$];
  int          hs_cnt, pulses, last_pop_cyc, done_rise;
  logic [37:0] first_hs, last_hs;
  logic        prev_valid, prev_ready, prev_pcu, prev_done;
  logic [37:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_prog(input logic [37:0] base, input int end_pc);
    for (int i = 0; i < 32; i++) begin
      prog[i] = base + 38'(i);
      if (i == end_pc) prog[i][37] = 1'b1;
    end
  endtask

  // Expected stream: program order up to the first END packet or the last PC.
  task automatic arm();
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(prog[i]);
      if (prog[i][37]) break;
    end
    hs_cnt = 0; pulses = 0; last_pop_cyc = -100; done_rise = -1;
  endtask

  task automatic fetch_reset();
    START = 1'b0;
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!DONE && n < budget) begin
      step();
      n++;
    end
    check(name, DONE, 1'b1);
    step();
  endtask

  // Per-cycle compare against the scoreboard and the handshake invariants.
  always @(negedge CLK) begin
    if (RST) begin
      prev_valid <= 1'b0; prev_ready <= 1'b0; prev_pcu <= 1'b0; prev_done <= 1'b0;
    end else begin
      check("valid_vs_count", PKT_VALID, (COUNT != 3'd0));
      check("count_bound", (COUNT <= 3'd4), 1'b1);
      check("busy_done_excl", (BUSY && DONE), 1'b0);
      if (!PKT_VALID) check("data_zero_empty", PKT_DATA, 38'd0);
      if (prev_valid && !prev_ready) check("data_stable", PKT_DATA, prev_data);
      if (PC_UPDATE) begin
        pulses++;
        check("pcu_single", prev_pcu, 1'b0);
      end
      if (PKT_VALID && PKT_READY) begin
        if (exp_q.size() == 0) begin
          check("hs_extra", 1'b1, 1'b0);
        end else begin
          check("hs_order", PKT_DATA, exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (hs_cnt == 0) first_hs = PKT_DATA;
        last_hs = PKT_DATA;
        hs_cnt++;
        last_pop_cyc = cyc;
      end
      if (DONE && !prev_done) done_rise = cyc;
      prev_valid <= PKT_VALID; prev_ready <= PKT_READY; prev_data <= PKT_DATA;
      prev_pcu <= PC_UPDATE; prev_done <= DONE;
    end
  end

  initial begin
    RST = 1'b1; START = 1'b1; PKT_READY = 1'b0;
    set_prog(38'd0, -1);
    arm();

    // Reset holds everything at zero even with START asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outputs", {PKT_VALID, PC_UPDATE, BUSY, DONE, COUNT}, 64'd0);
      check("rst_data", PKT_DATA, 38'd0);
    end
    RST = 1'b0; START = 1'b0;
    step();
    check("idle_after_rst", {BUSY, DONE}, 2'b00);

    // Normal run: packets 1..4, END on PC 3.
    set_prog(38'd1, 3);
    arm();
    PKT_READY = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
    check("start_cyc1_pcu", PC_UPDATE, 1'b0);
    check("start_cyc1_busy", BUSY, 1'b1);
    step();
    check("start_cyc2_pcu", PC_UPDATE, 1'b1);
    wait_done(200, "run_done_timeout");
    check("run_hs", hs_cnt, 4);
    check("run_pulses", pulses, 3);
    check("run_left", exp_q.size(), 0);
    check("run_done_lat", done_rise, last_pop_cyc + 2);
    check("run_first", first_hs, 38'h00_0000_0001);
    check("run_last", last_hs, 38'h20_0000_0004);
    check("run_busy_low", BUSY, 1'b0);

    // Back-pressure, then run to the PC limit with no END flag.
    fetch_reset();
    set_prog(38'h100, -1);
    arm();
    PKT_READY = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 40 && COUNT != 3'd4; i++) step();
    for (int i = 0; i < 6; i++) step();
    check("bp_full", COUNT, 3'd4);
    check("bp_busy", BUSY, 1'b1);
    check("bp_pulses", pulses, 4);
    check("bp_head", PKT_DATA, 38'h100);
    PKT_READY = 1'b1;
    step();
    PKT_READY = 1'b0;
    check("bp_after_pop", COUNT, 3'd3);
    check("bp_after_pop_pcu", PC_UPDATE, 1'b0);
    check("bp_new_head", PKT_DATA, 38'h101);
    step();
    check("bp_retry_write", COUNT, 3'd4);
    check("bp_retry_pcu", PC_UPDATE, 1'b1);
    PKT_READY = 1'b1;
    wait_done(400, "lim_done_timeout");
    check("lim_hs", hs_cnt, 32);
    check("lim_pulses", pulses, 31);
    check("lim_left", exp_q.size(), 0);
    check("lim_done_lat", done_rise, last_pop_cyc + 2);
    check("lim_last", last_hs, 38'h11F);

    // Reset in SETTLE with two buffered packets.
    fetch_reset();
    set_prog(38'h200, -1);
    arm();
    PKT_READY = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_update", PC_UPDATE, 1'b1);
    step();
    check("mid_settle_count", COUNT, 3'd2);
    check("mid_settle_pcu", PC_UPDATE, 1'b0);
    RST = 1'b1;
    step();
    check("mid_rst_clear", {PKT_VALID, PC_UPDATE, BUSY, DONE, COUNT}, 64'd0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_quiet", {PC_UPDATE, BUSY}, 2'b00);
    end

`ifdef PACKET_ISSUE_STATS_EN
    // Five packets with exactly two full-stall cycles.
    fetch_reset();
    set_prog(38'h300, 4);
    arm();
    PKT_READY = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 60 && STALL_CNT != 16'd1; i++) step();
    check("st_first_stall", STALL_CNT, 16'd1);
    PKT_READY = 1'b1;
    wait_done(200, "st_done_timeout");
    check("st_issued", ISSUED_CNT, 16'd5);
    check("st_stalls", STALL_CNT, 16'd2);
    START = 1'b1;
    step();
    START = 1'b0;
    check("st_clear", {ISSUED_CNT, STALL_CNT}, 32'd0);
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_issue.md
# packet_issue

Clocked issue stage directly downstream of the packet fetch stage. Reads the 38-bit packet presented for the current program counter and pulses the fetch stage's PC update. Buffers fetched packets in a small FIFO and hands them to the data-driven pipeline input over a valid/ready handshake. Runs one program load per START, stopping at an END-flagged packet or at the last PC.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16
- PW, 38: packet width
- PCW, 5: program counter width
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  single-cycle request to begin issuing; honoured only in IDLE or DONE
- PACKET_IN  in  PW  packet from fetch stage for the current PC
- PC_IN  in  PCW  current PC from fetch stage
- PC_UPDATE  out  1  one-cycle pulse telling the fetch stage to advance its PC
- PKT_VALID  out  1  head of FIFO is valid
- PKT_DATA  out  PW  head packet; stable while PKT_VALID=1 and PKT_READY=0
- PKT_READY  in  1  downstream accepts head when PKT_VALID=1 and PKT_READY=1
- BUSY  out  1  high in every state except IDLE and DONE
- DONE  out  1  high in DONE state
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Packet bit PW-1 (bit 37) is the END flag. All other bits are opaque.
- FSM states: IDLE, CAPTURE, UPDATE, SETTLE, DRAIN, DONE.
- IDLE or DONE with START=1 -> CAPTURE.
- CAPTURE, FIFO not full: write PACKET_IN.
  - END=1, or PC_IN == 2^PCW-1 -> DRAIN. No PC_UPDATE is issued, so the PC never wraps.
  - Otherwise -> UPDATE.
- CAPTURE, FIFO full: stay in CAPTURE; no write, no update.
- UPDATE: PC_UPDATE=1 for exactly this cycle. -> SETTLE.
- SETTLE: one idle cycle so the fetch stage's PACKET_IN and PC_IN settle. -> CAPTURE.
- DRAIN: no writes. When FIFO empty -> DONE.
- DONE: holds until START. START in DONE does not reset the fetch PC; the fetch stage is reset only by RST.
- START outside IDLE/DONE is ignored.
- FIFO is show-ahead: PKT_DATA = head entry, PKT_VALID = (COUNT != 0).
- Pop on PKT_VALID & PKT_READY.
- Full rule: when full, a write is blocked even if a pop occurs in the same cycle. The write retries next cycle.
- Simultaneous write and pop when not full: both happen, COUNT unchanged.

## Timing
- Reset values: state IDLE, COUNT=0, PKT_VALID=0, PKT_DATA=0, PC_UPDATE=0, BUSY=0, DONE=0. FIFO pointers cleared. Entries need not be cleared, but PKT_DATA reads 0 while empty.
- RST mid-operation: same cycle-edge clear. Any buffered packets are discarded.
- Write latency: a packet written at edge N shows PKT_VALID=1 from cycle N+1 if the FIFO was empty.
- Issue rate: one packet per 3 cycles (CAPTURE, UPDATE, SETTLE) when not back-pressured.
- PC_UPDATE is registered, from the FSM state only, never combinational from inputs.
- START to first PC_UPDATE: START sampled at edge 0, CAPTURE in cycle 1, UPDATE (pulse) in cycle 2.
- Last packet popped at edge M: DRAIN -> DONE at edge M+1. DONE high from cycle M+1.

## Configuration
- PACKET_ISSUE_STATS_EN defined:
  - Adds output ISSUED_CNT (16 bits), incremented on each completed output handshake and saturating at 0xFFFF.
  - Adds output STALL_CNT (16 bits), incremented each cycle in CAPTURE with the FIFO full, also saturating.
  - Both counters are cleared by RST and by an accepted START.
- Not defined: neither port exists and there is no counter logic.

## Structure
- Shared package packet_issue_pkg holds:
  - state enum (IDLE, CAPTURE, UPDATE, SETTLE, DRAIN, DONE)
  - END_BIT = 37
  - default PW/PCW constants, shared with the fetch stage
- One sub-module, pkt_fifo: parameterised synchronous show-ahead FIFO with push/pop/full/empty/count. The FSM lives in packet_issue.

## Test plan
- Reset: RST=1 for 3 cycles with START=1 -> all outputs 0 and state stays IDLE. After release, START pulse -> PC_UPDATE pulse exactly 2 cycles after START.
- Normal run, PKT_READY=1: fetch model returns packets 0x0_0000_0001..0x0_0000_0004 for PC 0..3, and PC 3 has bit 37 set. -> 4 handshakes in order, 3 PC_UPDATE pulses, DONE high one cycle after last pop.
- Back-pressure: DEPTH=4, PKT_READY=0, no END in the program. -> COUNT reaches 4, FSM holds in CAPTURE, no 5th PC_UPDATE. Raise PKT_READY -> order preserved, and the blocked write occurs the cycle after the first pop.
- PC limit: no END flag anywhere. -> packet at PC 31 is captured, no PC_UPDATE after it, DRAIN then DONE. Total of 32 packets, 31 pulses.
- Reset mid-run: RST during SETTLE with COUNT=2. -> next cycle COUNT=0, PKT_VALID=0, IDLE, and no spurious PC_UPDATE.
- Stats (macro defined): 5 packets, 2 stalled cycles. -> ISSUED_CNT=5, STALL_CNT=2. START in DONE clears both.
